// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer (8E1 when UART_TX_PARITY_EN is defined).
// Latency: a byte pushed into an empty FIFO with the line idle drives the start bit one clock later.
// Backpressure: none on uart_in; a push while full (and no pop that edge) is dropped and sets sticky overflow.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [8:0]                    uart_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          overflow_q;
  logic          empty;
  logic          full_int;
  logic          push;
  logic          pop;
  logic          drop;

  // Serializer state
  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          tx_q;
  logic          tx_d;
  logic          baud_done;

  assign empty     = (count_q == '0);
  assign full_int  = (count_q == DEPTH_C);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // A pop on the same edge frees a slot, so a push while full is still accepted then.
  assign push = uart_in[8] && (!full_int || pop);
  assign drop = uart_in[8] && full_int && !pop;

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents need no reset because the pointers are cleared.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= uart_in[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Next-state, baud/bit counters, pop request and next line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_done ? '0 : baud_cnt + 1'b1;
    bit_d   = bit_cnt;
    data_d  = data_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            data_d  = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    // Line level for the upcoming bit period, registered so tx never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Serializer state register; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign full       = full_int;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit period (minimum 2).
REQ-002 Parameter FIFO_DEPTH, default 8, byte entries in the transmit FIFO (power of two, minimum 2).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 uart_in  input  9  [8] write strobe, [7:0] byte; same packing as the core's uart_out bus.
REQ-006 tx  output  1  serial line; idles high.
REQ-007 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-008 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 overflow  output  1  sticky flag; a byte was dropped.

Function
REQ-011 Every rising edge with uart_in[8]=1 SHALL push uart_in[7:0] as one entry; a strobe held high for N cycles pushes N bytes.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-013 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the shift register and enter START on the same edge.
REQ-014 A byte pushed at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low from edge N+1.
REQ-015 Each state SHALL hold for exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1 and reset on every state change.
REQ-016 START SHALL drive tx=0; DATA SHALL send 8 bits LSB first; STOP SHALL drive tx=1 for one bit period.
REQ-017 At the end of STOP, the FSM SHALL pop and enter START on the same edge if the FIFO is non-empty (no idle gap between frames), else enter IDLE.
REQ-018 A push and a pop on the same edge SHALL both take effect and leave fifo_count unchanged, including when full=1.
REQ-019 A push while full with no pop on that edge SHALL be dropped and SHALL set overflow, which holds until reset.
REQ-020 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from fifo_count.
REQ-021 tx SHALL be driven from a register (glitch-free).

Reset
REQ-022 While reset_n=0 at a rising edge: tx=1, busy=0, full=0, fifo_count=0, overflow=0, state=IDLE, baud counter=0, and FIFO contents are discarded.
REQ-023 A reset mid-frame SHALL abort the frame, with tx=1 after that edge; no partial frame resumes.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, a PARITY state of one bit period SHALL follow DATA and send even parity (XOR of the 8 data bits), giving an 11-bit frame.
REQ-025 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP, giving a 10-bit frame.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-026 Hold reset_n=0 for 2 edges -> tx=1, busy=0, full=0, fifo_count=0, overflow=0.
REQ-027 Push 0x41 once -> tx low for 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles; busy=0 after the stop bit (frame of 40 cycles).
REQ-028 Push 0x55, 0xAA, 0x0F on 3 consecutive edges -> three contiguous frames of 120 cycles total with no idle between stop and start; fifo_count peaks at 2.
REQ-029 Push 10 bytes on 10 consecutive edges from idle -> 9 bytes accepted (1 shifting, 8 queued), full=1, the 10th byte dropped, overflow=1; exactly 9 frames transmitted.
REQ-030 Drop reset_n for 1 edge during DATA of the second of three queued frames -> tx=1 and fifo_count=0 after that edge; no further frames are sent.
REQ-031 With UART_TX_PARITY_EN defined: push 0x41 -> parity bit 0; push 0x07 -> parity bit 1; each frame is 44 cycles.
